// File: rtl/turn_ctrl_n.sv
// turn_ctrl_n: N-player turn controller for the keypad game.
// Sequences turns and rounds, enforces a per-turn timeout and stamps accepted moves from a 16-bit LFSR.
module turn_ctrl_n #(
  parameter  int PLAYERS = 2,
  parameter  int ROUNDS  = 4,
  parameter  int TIMEOUT = 1000,
  parameter  int RND_W   = 5,
  localparam int PW      = (PLAYERS > 2) ? $clog2(PLAYERS) : 1,
  localparam int RW      = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             en,
  output logic [PW-1:0]    mover,
  output logic [3:0]       move,
  output logic [RND_W-1:0] rnd,
  output logic             skip,
  output logic             timeout,
  output logic [PW-1:0]    whose,
  output logic [RW-1:0]    round,
  output logic             busy,
  output logic             done
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [15:0]   lfsr_r;

  logic lfsr_fb_s;
  logic start_s;
  logic accept_s;
  logic pass_s;
  logic expire_s;
  logic advance_s;
  logic last_player_s;
  logic last_turn_s;

  // Decode key events and turn-advance conditions for the current state.
  always_comb begin
    lfsr_fb_s     = lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5];
    start_s       = key_valid && (key_code == 4'd11);
    accept_s      = 1'b0;
    pass_s        = 1'b0;
    expire_s      = 1'b0;
    if (state_r == ST_WAIT) begin
      accept_s = key_valid && (key_code <= 4'd9);
      pass_s   = key_valid && (key_code == 4'd10);
      // A key arriving on the expiry cycle takes priority over the timeout.
      expire_s = !accept_s && !pass_s && (timer_r == TW'(TIMEOUT - 1));
    end else begin
      accept_s = 1'b0;
    end
    advance_s     = accept_s || pass_s || expire_s;
    last_player_s = (whose == PW'(PLAYERS - 1));
    last_turn_s   = last_player_s && (round == RW'(ROUNDS - 1));
  end

  // Game FSM with registered pulse/status outputs and the free-running LFSR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      timer_r <= '0;
      lfsr_r  <= 16'hACE1;
      en      <= 1'b0;
      mover   <= '0;
      move    <= 4'd0;
      rnd     <= '0;
      skip    <= 1'b0;
      timeout <= 1'b0;
      whose   <= '0;
      round   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      lfsr_r  <= {lfsr_fb_s, lfsr_r[15:1]};
      en      <= accept_s;
      skip    <= pass_s || expire_s;
      timeout <= expire_s;
      if (accept_s) begin
        mover <= whose;
        move  <= key_code;
        rnd   <= lfsr_r[RND_W-1:0];
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_WAIT;
            timer_r <= '0;
            whose   <= '0;
            round   <= '0;
            busy    <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (advance_s) begin
            timer_r <= '0;
            if (last_turn_s) begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (last_player_s) begin
              whose <= '0;
              round <= round + RW'(1);
            end else begin
              whose <= whose + PW'(1);
            end
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_DONE: begin
          if (start_s) begin
            state_r <= ST_IDLE;
            done    <= 1'b0;
            whose   <= '0;
            round   <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/turn_ctrl_n.md
# turn_ctrl_n

Parametrised N-player turn controller for the keypad game. Consumes debounced key codes from the keypad scanner, tracks whose turn it is across a configurable number of players and rounds, enforces a per-turn timeout, and stamps every accepted move with a pseudo-random value from an internal LFSR. Drives the LED/score logic through one-cycle move and skip pulses plus level status outputs.

## Interface
- PLAYERS, 2: number of players, legal range 2..8; PW = clog2(PLAYERS), min 1
- ROUNDS, 4: full rounds per game, legal range 1..15; RW = clog2(ROUNDS+1)
- TIMEOUT, 1000: cycles allowed per turn, legal range 2..2^20
- RND_W, 5: width of random stamp, legal range 1..16

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- key_valid  in  1  one-cycle strobe from keypad scanner
- key_code  in  4  0–9 digit, 10 '*', 11 '#', 12–15 ignored
- en  out  1  one-cycle pulse: move accepted
- mover  out  PW  player who made the accepted move (valid with en)
- move  out  4  accepted digit (valid with en)
- rnd  out  RND_W  random stamp (valid with en, held until next en)
- skip  out  1  one-cycle pulse: turn skipped (pass or timeout)
- timeout  out  1  one-cycle pulse: skip caused by timeout
- whose  out  PW  player currently to move
- round  out  RW  current round, 0-based
- busy  out  1  game in progress
- done  out  1  game finished

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE; all outputs 0.
- IDLE: key_valid with '#' → WAIT, whose=0, round=0, turn timer=0, busy=1. Other keys ignored.
- WAIT, key_valid with digit 0–9: accept move; en=1, mover=whose, move=key_code, rnd=LFSR[RND_W-1:0]; advance turn.
- WAIT, key_valid with '*': pass; skip=1, timeout=0; advance turn.
- WAIT, key_valid with '#' or 12–15: ignored; timer keeps running.
- WAIT, no accepted key, timer == TIMEOUT-1: skip=1, timeout=1; advance turn.
- Advance turn: timer←0; if whose==PLAYERS-1 then whose←0, round←round+1, else whose←whose+1. If whose==PLAYERS-1 and round==ROUNDS-1 → DONE instead (whose, round hold final values), busy=0, done=1.
- DONE: outputs hold; key_valid with '#' → IDLE, done=0, whose=0, round=0. Other keys ignored.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset, shifts every cycle in all states, never all-zero.
- rnd, mover, move hold last accepted values until next en; cleared only by reset.

## Timing
- Registered outputs. key_valid sampled at edge N → en/skip/timeout high for cycle N+1 only; whose/round/busy/done updated at the same edge.
- rnd = LFSR value present during cycle N (the sampling cycle).
- Timer counts every WAIT cycle, starts at 0 on turn entry; with no key, timeout pulse appears TIMEOUT cycles after turn entry.
- Key and timer expiry in same cycle: key wins (digit → en, '*' → skip with timeout=0); exactly one advance.
- en and skip never both high; timeout implies skip.
- Back-to-back key_valid on consecutive cycles: each handled; second applies to the new player.
- rst low at any time: immediate return to IDLE, all outputs 0, LFSR reseeded; no pulse emitted on release.

## Test plan
- PLAYERS=3, ROUNDS=2: '#' then six digits 1..6 spaced 5 cycles → en ×6, mover 0,1,2,0,1,2, round 0→1, after sixth move done=1, busy=0, whose=2, round=1.
- PLAYERS=2, TIMEOUT=8: '#' then idle → skip=timeout=1 at 8 cycles after start, whose 0→1; again 8 cycles later whose 1→0, round=1.
- TIMEOUT=8: digit 7 exactly on timer==7 cycle → en=1, move=7, skip=0, timeout=0, single advance.
- '*' in WAIT → skip=1, timeout=0, no en, rnd unchanged; '#' and code 13 in WAIT → no output change.
- Digit at known cycle after reset → rnd equals bench LFSR model (seed ACE1) low RND_W bits; RND_W=16 checks full state.
- rst low mid-WAIT (round=1, whose=1) → all outputs 0 asynchronously, IDLE; digits ignored until '#'; DONE then '#' → IDLE, done=0.
